// File: rtl/multiword_add_ctrl.sv
// Multi-word adder sequencer: drives one shared WIDTH-bit adder over WORDS cycles, LS word first.
// Optional subtract mode is built when MADD_SUB_EN is defined (adds the sub port).
module multiword_add_ctrl #(
    parameter int WIDTH = 32,
    parameter int WORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [WIDTH*WORDS-1:0]   op_a,
    input  logic [WIDTH*WORDS-1:0]   op_b,
    input  logic                     cin,
`ifdef MADD_SUB_EN
    input  logic                     sub,
`endif
    output logic                     busy,
    output logic                     done,
    output logic [WIDTH*WORDS-1:0]   result,
    output logic                     cout,
    output logic                     ovf,
    output logic [WIDTH-1:0]         add_a,
    output logic [WIDTH-1:0]         add_b,
    output logic                     add_cin,
    input  logic [WIDTH-1:0]         add_sum,
    input  logic                     add_cout
);
    localparam int N    = WIDTH * WORDS;
    localparam int IDXW = $clog2(WORDS);
    localparam logic [IDXW-1:0] LAST = IDXW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [N-1:0]     a_q, a_d, b_q, b_d, result_q, result_d;
    logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic             sub_q, sub_d;
    logic             start_sub;

`ifdef MADD_SUB_EN
    assign start_sub = sub;
`else
    assign start_sub = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            sub_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            sub_q    <= sub_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (idx_q == LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        sub_d    = sub_q;
        if (state_q == IDLE && start) begin
            a_d     = op_a;
            b_d     = op_b;
            sub_d   = start_sub;
            carry_d = start_sub ? 1'b1 : cin;
            idx_d   = '0;
            cout_d  = 1'b0;
            ovf_d   = 1'b0;
        end else if (state_q == RUN) begin
            result_d[idx_q*WIDTH +: WIDTH] = add_sum;
            carry_d = add_cout;
            if (idx_q == LAST) begin
                // Overflow judged on the MS word exactly as the adder saw it (B already inverted for subtract).
                idx_d  = '0;
                cout_d = add_cout;
                ovf_d  = (add_a[WIDTH-1] == add_b[WIDTH-1]) && (add_sum[WIDTH-1] != add_a[WIDTH-1]);
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_comb begin
        busy    = (state_q != IDLE);
        done    = (state_q == DONE);
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state_q == RUN) begin
            add_a   = a_q[idx_q*WIDTH +: WIDTH];
            add_b   = sub_q ? ~b_q[idx_q*WIDTH +: WIDTH] : b_q[idx_q*WIDTH +: WIDTH];
            add_cin = carry_q;
        end
    end

    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_multiword_add_ctrl.sv
// Self-checking bench for multiword_add_ctrl (WIDTH=32, WORDS=4) with a behavioural adder
// and a whole-operand arithmetic reference model.
module tb_multiword_add_ctrl;
    localparam int WIDTH = 32;
    localparam int WORDS = 4;
    localparam int N     = WIDTH * WORDS;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [N-1:0]     op_a = '0, op_b = '0;
    logic             cin = 1'b0;
    logic             sub = 1'b0;
    logic             busy, done, cout, ovf;
    logic [N-1:0]     result;
    logic [WIDTH-1:0] add_a, add_b, add_sum;
    logic             add_cin, add_cout;

    int checks = 0;
    int failures = 0;

    multiword_add_ctrl #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
`ifdef MADD_SUB_EN
        .sub(sub),
`endif
        .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout)
    );

    always #5 clk = ~clk;

    always_comb {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                          input logic s, input string tag);
        logic [N-1:0] beff;
        logic [N:0]   full;
        logic         eovf;
        int           cyc, busy_cnt;
        beff = s ? ~b : b;
        full = {1'b0, a} + {1'b0, beff} + {{N{1'b0}}, (s ? 1'b1 : c)};
        eovf = (a[N-1] == beff[N-1]) && (full[N-1] != a[N-1]);
        op_a = a; op_b = b; cin = c; sub = s; start = 1'b1;
        tick();
        start = 1'b0;
        op_a = rnd128(); op_b = rnd128(); cin = ~c; sub = ~s;
        chk({tag, "_busy_start"}, N'(busy), N'(1));
        busy_cnt = busy ? 1 : 0;
        cyc = 0;
        while (!done && cyc < 20) begin
            tick();
            cyc++;
            if (busy) busy_cnt++;
        end
        chk({tag, "_latency"}, N'(cyc), N'(WORDS));
        chk({tag, "_result"}, result, full[N-1:0]);
        chk({tag, "_cout"}, N'(cout), N'(full[N]));
        chk({tag, "_ovf"}, N'(ovf), N'(eovf));
        tick();
        chk({tag, "_done_pulse"}, N'(done), N'(0));
        chk({tag, "_busy_cycles"}, N'(busy_cnt), N'(WORDS + 1));
        chk({tag, "_hold_result"}, result, full[N-1:0]);
    endtask

    initial begin
        logic [N-1:0] ha, hb, prev_res;
        logic [N:0]   hfull;
        int           rises, dones, first_rise, last_rise, cyc;
        logic         pbusy;

        #1;
        chk("reset_busy", N'(busy), N'(0));
        chk("reset_done", N'(done), N'(0));
        chk("reset_result", result, '0);
        chk("reset_cout_ovf", N'({cout, ovf}), N'(0));
        chk("reset_add_a", N'(add_a), N'(0));
        tick();
        tick();
        rst = 1'b0;
        tick();

        run_op({32'h0, {3{32'hFFFF_FFFF}}}, N'(1), 1'b0, 1'b0, "ripple");
        run_op({N{1'b1}}, '0, 1'b1, 1'b0, "wrap");
        run_op({1'b0, {(N-1){1'b1}}}, N'(1), 1'b0, 1'b0, "sovf");
        chk("idle_add_outs", N'({add_a, add_b, add_cin}), N'(0));
        for (int i = 0; i < 8; i++)
            run_op(rnd128(), rnd128(), 1'($urandom), 1'b0, "rand");

        // Start held high: accepted only in IDLE, every 6 cycles.
        ha = rnd128(); hb = rnd128();
        hfull = {1'b0, ha} + {1'b0, hb};
        op_a = ha; op_b = hb; cin = 1'b0; sub = 1'b0; start = 1'b1;
        rises = 0; dones = 0; first_rise = -1; last_rise = -1; pbusy = busy;
        for (int k = 1; k <= 13; k++) begin
            tick();
            if (busy && !pbusy) begin
                rises++;
                if (first_rise < 0) first_rise = k;
                last_rise = k;
            end
            if (done) dones++;
            pbusy = busy;
        end
        start = 1'b0;
        chk("hold_accepts", N'(rises), N'(3));
        chk("hold_spacing", N'(last_rise - first_rise), N'(12));
        chk("hold_done_count", N'(dones), N'(2));
        cyc = 0;
        while (!done && cyc < 20) begin tick(); cyc++; end
        chk("hold_result", result, hfull[N-1:0]);
        tick();

        // Reset mid-operation at idx=2.
        prev_res = result;
        op_a = rnd128(); op_b = rnd128(); start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("midrst_partial_busy", N'(busy), N'(1));
        rst = 1'b1;
        #1;
        chk("midrst_busy", N'(busy), N'(0));
        chk("midrst_done", N'(done), N'(0));
        chk("midrst_result", result, '0);
        chk("midrst_cout_ovf", N'({cout, ovf}), N'(0));
        #2;
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (done || busy) dones++;
        end
        chk("midrst_no_done", N'(dones), N'(0));
        chk("midrst_prev_gone", N'(result == prev_res && prev_res != '0), N'(0));
        run_op(rnd128(), rnd128(), 1'b1, 1'b0, "after_rst");

`ifdef MADD_SUB_EN
        run_op(N'(5), N'(7), 1'b0, 1'b1, "sub_neg");
        chk("sub_neg_value", result, {{(N-2){1'b1}}, 2'b10});
        run_op(N'(7), N'(5), 1'b0, 1'b1, "sub_pos");
        chk("sub_pos_value", result, N'(2));
        for (int i = 0; i < 4; i++)
            run_op(rnd128(), rnd128(), 1'($urandom), 1'b1, "sub_rand");
        run_op(rnd128(), rnd128(), 1'b1, 1'b0, "sub_off");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
